// File: rtl/rv32m_pkg.sv
// rv32m_pkg: RV32M funct3 codes and multiply/divide FSM state encoding.
package rv32m_pkg;
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;
  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_e;
endpackage

// File: rtl/mdu_datapath.sv
// mdu_datapath: one shift-add / restoring shift-subtract step on the shared
// 2*XLEN accumulator, plus the final sign correction and result select.
module mdu_datapath
  import rv32m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        op,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  input  logic              neg,
  input  logic              rneg,
  output logic [2*XLEN-1:0] step,
  output logic [XLEN-1:0]   res
);
  logic [XLEN:0]     sum;
  logic [XLEN:0]     trial;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   q;
  logic [XLEN-1:0]   r;
  // multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}
  assign sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
  assign trial = acc[2*XLEN-1:XLEN-1];
  assign diff  = trial - {1'b0, opnd};
  assign step  = !op[2] ? {sum, acc[XLEN-1:1]}
               : !diff[XLEN] ? {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1}
               : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  assign prod  = neg ? -acc : acc;
  assign q     = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign r     = rneg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  assign res   = op[2] ? (op[1] ? r : q)
               : (op == OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide, one result bit per cycle,
// valid/ready on both sides with flush abort.
module mul_div_unit
  import rv32m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op_code,
  input  logic [XLEN-1:0] input_a,
  input  logic [XLEN-1:0] input_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   out_q, out_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d, rneg_q, rneg_d;
  logic              a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0]   abs_a, abs_b, spec;
  logic [2*XLEN-1:0] step;
  logic [XLEN-1:0]   res;
  assign a_neg = input_a[XLEN-1] && (op_code == OP_MULH || op_code == OP_MULHSU
                                     || op_code == OP_DIV || op_code == OP_REM);
  assign b_neg = input_b[XLEN-1] && (op_code == OP_MULH || op_code == OP_DIV
                                     || op_code == OP_REM);
  assign abs_a = a_neg ? -input_a : input_a;
  assign abs_b = b_neg ? -input_b : input_b;
  assign div0  = op_code[2] && input_b == '0;
  assign ovf   = (op_code == OP_DIV || op_code == OP_REM) && input_a == MIN_INT && input_b == '1;
  assign spec  = div0 ? (op_code[1] ? input_a : '1) : (op_code[1] ? '0 : MIN_INT);
  mdu_datapath #(.XLEN(XLEN)) u_dp (
    .op(op_q), .acc(acc_q), .opnd(opnd_q), .neg(neg_q), .rneg(rneg_q),
    .step(step), .res(res)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    out_d   = out_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    if (flush) state_d = IDLE;
    else case (state_q)
      IDLE: if (in_valid) begin
        op_d   = op_code;
        opnd_d = abs_b;
        neg_d  = a_neg ^ b_neg;
        rneg_d = a_neg;
        if (div0 || ovf) begin
          out_d   = spec;
          state_d = DONE;
        end else begin
          acc_d   = {{XLEN{1'b0}}, abs_a};
          cnt_d   = CNT_W'(XLEN);
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d   = step;
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = cnt_q == CNT_W'(1) ? FIX : BUSY;
      end
      FIX: begin
        out_d   = res;
        state_d = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      out_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      out_q   <= out_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out       = out_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors with hand-computed results, latency,
// backpressure, flush and async reset checks.
module tb_mul_div_unit;
  logic        clk = 0, rst_n = 0, in_valid = 0, flush = 0, out_ready = 0;
  logic [2:0]  op_code = '0;
  logic [31:0] input_a = '0, input_b = '0;
  logic        in_ready, out_valid;
  logic [31:0] out;
  int          n_chk = 0, n_fail = 0;
  mul_div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_code(op_code), .input_a(input_a), .input_b(input_b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // issues one request and waits for out_valid; lat counts edges after the handshake edge
  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, b,
                     input logic [31:0] exp, input int exp_lat);
    int lat;
    logic busy_ok;
    op_code = op; input_a = a; input_b = b; in_valid = 1;
    tick();
    in_valid = 0;
    lat = 0;
    busy_ok = 1;
    while (!out_valid && lat < 100) begin
      busy_ok &= !in_ready;
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_out"}, out, exp);
    check({tag, "_busy_ready"}, {31'b0, busy_ok && !in_ready}, 32'd1);
  endtask
  task automatic release_out(input string tag);
    out_ready = 1;
    tick();
    out_ready = 0;
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
  endtask
  initial begin
    int seen;
    #12;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out", out, 32'd0);
    rst_n = 1;
    tick();
    run("mul", 3'b000, 32'd7, 32'd6, 32'd42, 33);
    release_out("mul");
    run("mulh", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    release_out("mulh");
    run("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    release_out("mulhsu");
    run("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    release_out("mulhu");
    run("mul_neg", 3'b000, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 33);
    release_out("mul_neg");
    run("div", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    release_out("div");
    run("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    release_out("rem");
    run("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    release_out("divu");
    run("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    release_out("remu");
    run("div_negb", 3'b100, 32'd20, 32'hFFFFFFFA, 32'hFFFFFFFD, 33);
    release_out("div_negb");
    run("rem_negb", 3'b110, 32'd20, 32'hFFFFFFFA, 32'd2, 33);
    release_out("rem_negb");
    run("divu0", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 0);
    release_out("divu0");
    run("remu0", 3'b111, 32'd5, 32'd0, 32'd5, 0);
    release_out("remu0");
    run("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
    release_out("div_ovf");
    run("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0);
    release_out("rem_ovf");
    run("hold", 3'b000, 32'd11, 32'd13, 32'd143, 33);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_out", out, 32'd143);
      check("hold_valid", {31'b0, out_valid}, 32'd1);
    end
    release_out("hold");
    op_code = 3'b101; input_a = 32'd5; input_b = 32'd0; in_valid = 1; flush = 1;
    tick();
    in_valid = 0; flush = 0;
    check("flush_idle_ready", {31'b0, in_ready}, 32'd1);
    check("flush_idle_valid", {31'b0, out_valid}, 32'd0);
    op_code = 3'b000; input_a = 32'd21; input_b = 32'd2; in_valid = 1;
    tick();
    in_valid = 0;
    repeat (9) tick();
    flush = 1;
    tick();
    flush = 0;
    check("flush_ready", {31'b0, in_ready}, 32'd1);
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    seen = 0;
    repeat (40) begin
      tick();
      seen += int'(out_valid);
    end
    check("flush_no_valid", 32'(seen), 32'd0);
    op_code = 3'b000; input_a = 32'd21; input_b = 32'd2; in_valid = 1;
    tick();
    in_valid = 0;
    repeat (5) tick();
    rst_n = 0;
    #1;
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_out", out, 32'd0);
    tick();
    rst_n = 1;
    tick();
    run("mul_after_rst", 3'b000, 32'd3, 32'd3, 32'd9, 33);
    release_out("mul_after_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
